// File: rtl/interrupt_ctrl.sv
// N-channel priority interrupt controller with mask, level/edge mode,
// pending register and ACK/EOI handshake to the core.
module interrupt_ctrl #(
   parameter int NUM_CH = 16,
   parameter int ID_W   = 4,
   parameter int DATA_W = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] INT_REQ,
   input  logic              read_data,
   input  logic              write_data,
   input  logic [1:0]        ADDR,
   input  logic [DATA_W-1:0] DATA_IN,
   output logic [DATA_W-1:0] DATA_OUT,
   output logic              INT2COR,
   output logic [ID_W-1:0]   NUM_INT,
   input  logic              INT_ACK,
   input  logic              INT_EOI
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [ID_W-1:0]   num_n;
   logic [ID_W-1:0]   win;
   logic [NUM_CH-1:0] mask, mode, pend, int_prev;
   logic [NUM_CH-1:0] elig, pend_n, pend_edge;
   logic [NUM_CH-1:0] w1c, ack_clr;
   logic [DATA_W-1:0] rd_val;
   logic              ack_go;

   assign elig    = pend & mask;
   assign INT2COR = (state == REQ);
   assign ack_go  = (state == REQ) && INT_ACK;

   always_comb begin
      win = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (elig[i]) win = ID_W'(i);
   end

   // Edge bits: a fresh rising edge beats any clear in the same cycle.
   always_comb begin
      w1c       = (write_data && ADDR == 2'd2) ? DATA_IN[NUM_CH-1:0] : '0;
      ack_clr   = ack_go ? ({{(NUM_CH-1){1'b0}}, 1'b1} << NUM_INT) : '0;
      pend_edge = (INT_REQ & ~int_prev) | (pend & ~(w1c | ack_clr));
      pend_n    = (mode & pend_edge) | (~mode & INT_REQ);
   end

   always_comb begin
      state_n = state;
      num_n   = NUM_INT;
      unique case (state)
         IDLE: begin
            if (elig != '0) begin
               state_n = REQ;
               num_n   = win;
            end
         end
         REQ: begin
            if (INT_ACK)
               state_n = SERVICE;
            else if (!elig[NUM_INT])
               state_n = IDLE;
         end
         SERVICE: begin
            if (INT_EOI) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      rd_val = '0;
      unique case (ADDR)
         2'd0: rd_val = DATA_W'(mask);
         2'd1: rd_val = DATA_W'(mode);
         2'd2: rd_val = DATA_W'(pend);
         2'd3: rd_val = DATA_W'({state, INT2COR, NUM_INT});
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state    <= IDLE;
         NUM_INT  <= '0;
         mask     <= '0;
         mode     <= '0;
         pend     <= '0;
         int_prev <= '0;
         DATA_OUT <= '0;
      end else begin
         state    <= state_n;
         NUM_INT  <= num_n;
         pend     <= pend_n;
         int_prev <= INT_REQ;
         if (write_data && ADDR == 2'd0) mask <= DATA_IN[NUM_CH-1:0];
         if (write_data && ADDR == 2'd1) mode <= DATA_IN[NUM_CH-1:0];
         if (read_data) DATA_OUT <= rd_val;
      end
   end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed vector table, hand sequences and
// randomized traffic checked against a behavioural model.
module tb_interrupt_ctrl;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [15:0] INT_REQ = '0;
   logic        read_data = 1'b0;
   logic        write_data = 1'b0;
   logic [1:0]  ADDR = '0;
   logic [15:0] DATA_IN = '0;
   logic [15:0] DATA_OUT;
   logic        INT2COR;
   logic [3:0]  NUM_INT;
   logic        INT_ACK = 1'b0;
   logic        INT_EOI = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   interrupt_ctrl #(.NUM_CH(16), .ID_W(4), .DATA_W(16)) dut (
      .CLK(CLK), .RESET(RESET), .INT_REQ(INT_REQ),
      .read_data(read_data), .write_data(write_data),
      .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
      .INT2COR(INT2COR), .NUM_INT(NUM_INT),
      .INT_ACK(INT_ACK), .INT_EOI(INT_EOI)
   );

   always #5 CLK = ~CLK;

   // Behavioural model: per-channel bits, state as 0/1/2
   bit [15:0] m_mask, m_mode, m_pend, m_prev, m_dout;
   int        m_st, m_num;
   bit        m_irq;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model(input bit rst, input bit [15:0] req, input bit rd,
                        input bit wr, input bit [1:0] a, input bit [15:0] d,
                        input bit ack, input bit eoi);
      bit [15:0] elig, np;
      int        win, nst, nnum;
      bit        nirq, ackclr;
      if (!rst) begin
         m_mask = 0; m_mode = 0; m_pend = 0; m_prev = 0;
         m_dout = 0; m_st = 0; m_num = 0; m_irq = 0;
         return;
      end
      if (rd) begin
         case (a)
            2'd0: m_dout = m_mask;
            2'd1: m_dout = m_mode;
            2'd2: m_dout = m_pend;
            default: m_dout = 16'(m_st * 32 + int'(m_irq) * 16 + m_num);
         endcase
      end
      elig = m_pend & m_mask;
      win = -1;
      for (int i = 15; i >= 0; i--) if (elig[i]) win = i;
      nst = m_st; nnum = m_num; nirq = m_irq; ackclr = 0;
      if (m_st == 0) begin
         if (win >= 0) begin nst = 1; nnum = win; nirq = 1; end
      end else if (m_st == 1) begin
         if (ack) begin nst = 2; nirq = 0; ackclr = 1; end
         else if (!elig[m_num]) begin nst = 0; nirq = 0; end
      end else if (eoi) begin
         nst = 0;
      end
      for (int i = 0; i < 16; i++) begin
         if (!m_mode[i]) np[i] = req[i];
         else if (req[i] && !m_prev[i]) np[i] = 1'b1;
         else if ((wr && a == 2'd2 && d[i]) || (ackclr && i == m_num))
            np[i] = 1'b0;
         else np[i] = m_pend[i];
      end
      if (wr && a == 2'd0) m_mask = d;
      if (wr && a == 2'd1) m_mode = d;
      m_pend = np; m_prev = req;
      m_st = nst; m_num = nnum; m_irq = nirq;
   endtask

   // One clock: drive, edge, model update, compare #1 after the edge.
   task automatic cyc(input bit rst, input bit [15:0] req, input bit rd,
                      input bit wr, input bit [1:0] a, input bit [15:0] d,
                      input bit ack, input bit eoi);
      RESET = rst; INT_REQ = req; read_data = rd; write_data = wr;
      ADDR = a; DATA_IN = d; INT_ACK = ack; INT_EOI = eoi;
      @(posedge CLK);
      model(rst, req, rd, wr, a, d, ack, eoi);
      #1;
      chk("mdl_irq", 32'(INT2COR), 32'(m_irq));
      chk("mdl_num", 32'(NUM_INT), 32'(m_num));
      chk("mdl_dout", 32'(DATA_OUT), 32'(m_dout));
      @(negedge CLK);
   endtask

   task automatic idle(input bit [15:0] req);
      cyc(1, req, 0, 0, 2'd0, 16'h0, 0, 0);
   endtask

   typedef struct {
      bit        rst;
      bit [15:0] req;
      bit        rd, wr;
      bit [1:0]  a;
      bit [15:0] d;
      bit        ack, eoi;
      bit        irq;
      bit [3:0]  num;
      bit [15:0] dout;
   } vec_t;

   vec_t tbl[13];

   initial begin
      // reset with all lines high, then priority 4 over 5, then 5
      tbl[0]  = '{0, 16'hFFFF, 0, 0, 2'd0, 16'h0000, 0, 0, 0, 4'd0, 16'h0000};
      tbl[1]  = '{0, 16'hFFFF, 1, 0, 2'd0, 16'h0000, 0, 0, 0, 4'd0, 16'h0000};
      tbl[2]  = '{1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 0, 4'd0, 16'h0000};
      tbl[3]  = '{1, 16'h0030, 0, 1, 2'd0, 16'hFFFF, 0, 0, 0, 4'd0, 16'h0000};
      tbl[4]  = '{1, 16'h0030, 0, 0, 2'd0, 16'h0000, 0, 0, 1, 4'd4, 16'h0000};
      tbl[5]  = '{1, 16'h0030, 1, 0, 2'd3, 16'h0000, 0, 0, 1, 4'd4, 16'h0034};
      tbl[6]  = '{1, 16'h0020, 0, 0, 2'd0, 16'h0000, 1, 0, 0, 4'd4, 16'h0034};
      tbl[7]  = '{1, 16'h0020, 0, 0, 2'd0, 16'h0000, 0, 1, 0, 4'd4, 16'h0034};
      tbl[8]  = '{1, 16'h0020, 0, 0, 2'd0, 16'h0000, 0, 0, 1, 4'd5, 16'h0034};
      tbl[9]  = '{1, 16'h0020, 1, 0, 2'd3, 16'h0000, 0, 0, 1, 4'd5, 16'h0035};
      tbl[10] = '{1, 16'h0020, 1, 0, 2'd2, 16'h0000, 1, 0, 0, 4'd5, 16'h0020};
      tbl[11] = '{1, 16'h0000, 0, 0, 2'd0, 16'h0000, 0, 1, 0, 4'd5, 16'h0020};
      tbl[12] = '{1, 16'h0000, 1, 0, 2'd3, 16'h0000, 0, 0, 0, 4'd5, 16'h0005};

      @(negedge CLK);
      for (int i = 0; i < 13; i++) begin
         cyc(tbl[i].rst, tbl[i].req, tbl[i].rd, tbl[i].wr, tbl[i].a,
             tbl[i].d, tbl[i].ack, tbl[i].eoi);
         chk($sformatf("tbl%0d_irq", i), 32'(INT2COR), 32'(tbl[i].irq));
         chk($sformatf("tbl%0d_num", i), 32'(NUM_INT), 32'(tbl[i].num));
         chk($sformatf("tbl%0d_dout", i), 32'(DATA_OUT), 32'(tbl[i].dout));
      end

      // edge mode: single pulse on ch0
      cyc(1, 16'h0000, 0, 1, 2'd1, 16'h0001, 0, 0);
      cyc(1, 16'h0000, 0, 1, 2'd0, 16'h0001, 0, 0);
      cyc(1, 16'h0001, 0, 0, 2'd0, 16'h0000, 0, 0);
      idle(16'h0000);
      chk("edge_irq", 32'(INT2COR), 32'd1);
      chk("edge_num", 32'(NUM_INT), 32'd0);
      cyc(1, 16'h0000, 0, 0, 2'd0, 16'h0000, 1, 0);
      cyc(1, 16'h0000, 1, 0, 2'd2, 16'h0000, 0, 0);
      chk("edge_pend_ack", 32'(DATA_OUT), 32'd0);
      cyc(1, 16'h0000, 0, 0, 2'd0, 16'h0000, 0, 1);
      for (int i = 0; i < 3; i++) idle(16'h0000);
      chk("edge_no_rereq", 32'(INT2COR), 32'd0);

      // withdraw: level ch3 masked off while in REQ
      cyc(1, 16'h0008, 0, 1, 2'd1, 16'h0000, 0, 0);
      cyc(1, 16'h0008, 0, 1, 2'd0, 16'h0008, 0, 0);
      idle(16'h0008);
      chk("wd_irq_on", 32'(INT2COR), 32'd1);
      chk("wd_num", 32'(NUM_INT), 32'd3);
      cyc(1, 16'h0008, 0, 1, 2'd0, 16'h0000, 0, 0);
      idle(16'h0008);
      chk("wd_irq_off", 32'(INT2COR), 32'd0);
      cyc(1, 16'h0008, 1, 0, 2'd3, 16'h0000, 0, 0);
      chk("wd_stat", 32'(DATA_OUT), 32'h0003);

      // no pre-emption: ch7 holds against ch1
      cyc(1, 16'h0080, 0, 1, 2'd0, 16'hFFFF, 0, 0);
      idle(16'h0080);
      idle(16'h0082);
      chk("np_req_num", 32'(NUM_INT), 32'd7);
      cyc(1, 16'h0082, 0, 0, 2'd0, 16'h0000, 1, 0);
      idle(16'h0082);
      chk("np_svc_num", 32'(NUM_INT), 32'd7);
      cyc(1, 16'h0082, 0, 0, 2'd0, 16'h0000, 0, 1);
      idle(16'h0082);
      chk("np_ch1_num", 32'(NUM_INT), 32'd1);
      chk("np_ch1_irq", 32'(INT2COR), 32'd1);
      cyc(1, 16'h0082, 0, 0, 2'd0, 16'h0000, 1, 0);
      cyc(1, 16'h0082, 0, 0, 2'd0, 16'h0000, 0, 1);
      cyc(1, 16'h0082, 0, 1, 2'd0, 16'h0000, 0, 0);
      cyc(1, 16'h0000, 0, 1, 2'd1, 16'h0002, 0, 0);
      cyc(1, 16'h0002, 0, 1, 2'd2, 16'h0002, 0, 0);
      cyc(1, 16'h0002, 1, 0, 2'd2, 16'h0000, 0, 0);
      chk("set_beats_w1c", 32'(DATA_OUT), 32'h0002);
      cyc(1, 16'h0002, 0, 1, 2'd2, 16'h0002, 0, 0);
      cyc(1, 16'h0002, 1, 0, 2'd2, 16'h0000, 0, 0);
      chk("w1c_clears", 32'(DATA_OUT), 32'h0000);

      // reset in SERVICE, then a stray EOI
      cyc(1, 16'h0004, 0, 1, 2'd0, 16'hFFFF, 0, 0);
      idle(16'h0004);
      cyc(1, 16'h0004, 0, 0, 2'd0, 16'h0000, 1, 0);
      cyc(0, 16'h0004, 0, 0, 2'd0, 16'h0000, 0, 0);
      chk("rst_svc_irq", 32'(INT2COR), 32'd0);
      chk("rst_svc_num", 32'(NUM_INT), 32'd0);
      cyc(1, 16'h0000, 0, 0, 2'd0, 16'h0000, 0, 1);
      chk("eoi_ignored_num", 32'(NUM_INT), 32'd0);
      cyc(1, 16'h0000, 1, 0, 2'd3, 16'h0000, 0, 0);
      chk("eoi_ignored_stat", 32'(DATA_OUT), 32'h0000);

      // randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         bit [15:0] rq, dd;
         bit        rs, rd, wr, ak, eo;
         bit [1:0]  aa;
         rs = ($urandom_range(0, 79) != 0);
         rq = 16'($urandom) & 16'($urandom);
         rd = ($urandom_range(0, 2) == 0);
         wr = ($urandom_range(0, 5) == 0);
         aa = 2'($urandom_range(0, 3));
         dd = 16'($urandom);
         ak = ($urandom_range(0, 3) == 0);
         eo = ($urandom_range(0, 3) == 0);
         cyc(rs, rq, rd, wr, aa, dd, ak, eo);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
